// File: rtl/rx_chan_packer.sv
// Packs 1..4 channel words per strobe into a 16-bit FIFO, dropping whole sets when the FIFO or packer is busy.
// Optional dropped-set counter: define RX_PACKER_OVR_CNT_EN to build ovr_cnt; otherwise it is tied to zero.
module rx_chan_packer #(
    parameter int FIFO_AW = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           nwords,
    input  logic                 strobe,
    input  logic [15:0]          ch0,
    input  logic [15:0]          ch1,
    input  logic [15:0]          ch2,
    input  logic [15:0]          ch3,
    input  logic                 rd_en,
    input  logic                 clear_status,
    output logic [15:0]          dout,
    output logic                 empty,
    output logic [FIFO_AW:0]     count,
    output logic                 overrun,
    output logic [15:0]          ovr_cnt,
    output logic                 o_dbg_state,
    output logic [1:0]           o_dbg_idx
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [15:0]          r_word [4];
    logic [1:0]           r_last_idx;
    logic [1:0]           r_idx;

    logic [15:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [FIFO_AW:0]     r_count;
    logic [FIFO_AW:0]     w_count_next;
    logic                 r_empty;
    logic [15:0]          r_dout;
    logic                 r_overrun;

    logic                 w_nwords_ok;
    logic                 w_strobe_qual;
    logic [FIFO_AW:0]     w_free;
    logic                 w_space_ok;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_wr;
    logic                 w_last;
    logic                 w_pop;

    // Space is judged on the occupancy registered at the strobe edge; a concurrent pop earns no credit.
    assign w_nwords_ok   = (nwords >= 3'd1) && (nwords <= 3'd4);
    assign w_strobe_qual = strobe && enable && w_nwords_ok;
    assign w_free        = (FIFO_AW + 1)'(DEPTH) - r_count;
    assign w_space_ok    = (w_free >= (FIFO_AW + 1)'(nwords));
    assign w_pop         = rd_en && !r_empty;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_wr         = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe_qual) begin
                    if (w_space_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = S_WRITE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_wr   = 1'b1;
                w_last = (r_idx == r_last_idx);
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
                if (w_strobe_qual) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= 2'd0;
        end else if (w_accept) begin
            r_idx <= 2'd0;
        end else if (w_wr) begin
            r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
        end
    end

    // The sample set is captured once so the channel inputs may change while it drains.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_word[0]  <= ch0;
            r_word[1]  <= ch1;
            r_word[2]  <= ch2;
            r_word[3]  <= ch3;
            r_last_idx <= 2'(nwords - 3'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr && !reset) begin
            r_mem[r_wptr] <= r_word[r_idx];
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + (FIFO_AW + 1)'(1);
            2'b01:   w_count_next = r_count - (FIFO_AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_dout  <= 16'h0000;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_dout <= r_mem[r_rptr];
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_status) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef RX_PACKER_OVR_CNT_EN
    logic [15:0] r_ovr_cnt;

    // A drop coinciding with a clear restarts the count at one rather than losing the event.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovr_cnt <= 16'h0000;
        end else if (w_drop) begin
            if (clear_status) begin
                r_ovr_cnt <= 16'h0001;
            end else if (r_ovr_cnt != 16'hFFFF) begin
                r_ovr_cnt <= r_ovr_cnt + 16'h0001;
            end
        end else if (clear_status) begin
            r_ovr_cnt <= 16'h0000;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`else
    assign ovr_cnt = 16'h0000;
`endif

    assign dout        = r_dout;
    assign empty       = r_empty;
    assign count       = r_count;
    assign overrun     = r_overrun;
    assign o_dbg_state = (r_state == S_WRITE);
    assign o_dbg_idx   = r_idx;

endmodule
